// File: rtl/popcount_seq_ctrl_pkg.sv
// Shared definitions for the sequential popcount engine: controller states,
// slice width and slice-count helper.
package popcount_pkg;

  localparam int SLICE_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nslice(input int width);
    return (width + SLICE_W - 1) / SLICE_W;
  endfunction

endpackage

// File: rtl/popcount_seq_ctrl_if.sv
// Input-word and result handshakes of the popcount engine; the master side
// produces words and consumes counts.
interface popcount_seq_ctrl_if #(
  parameter int WIDTH = 40
);
  localparam int OUT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count
  );
endinterface

// File: rtl/popcount_seq_ctrl_ones_count5.sv
// Combinational 5-input ones counter; c carries the count with weights 1, 2, 4.
module ones_count5 (
  input  logic       x0,
  input  logic       x1,
  input  logic       x2,
  input  logic       x3,
  input  logic       x4,
  output logic [2:0] c
);

  assign c = {2'b00, x0} + {2'b00, x1} + {2'b00, x2} + {2'b00, x3} + {2'b00, x4};

endmodule

// File: rtl/popcount_seq_ctrl.sv
// Sequential popcount: one word is fed 5 bits per cycle through a single
// ones_count5 slice and the slice counts are accumulated into the result.
module popcount_seq_ctrl
  import popcount_pkg::*;
#(
  parameter int WIDTH = 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  popcount_seq_ctrl_if.slave   bus,
  output logic                 busy
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int OUT_W  = $clog2(WIDTH + 1);
  localparam int PAD_W  = NSLICE * SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int SUM_W  = (OUT_W > 3) ? OUT_W : 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t             state_r, state_n;
  logic [PAD_W-1:0]   word_r, word_n;
  logic [IDX_W-1:0]   idx_r, idx_n;
  logic [OUT_W-1:0]   acc_r, acc_n;
  logic               in_ready_r, out_valid_r, busy_r;
  logic [2:0]         cnt_s;
  logic [SUM_W-1:0]   sum_s;

  // The word shifts down one slice per RUN cycle, so the low 5 bits are
  // always the current slice; padding bits above WIDTH were loaded as zero.
  ones_count5 u_slice (
    .x0 (word_r[0]),
    .x1 (word_r[1]),
    .x2 (word_r[2]),
    .x3 (word_r[3]),
    .x4 (word_r[4]),
    .c  (cnt_s)
  );

  assign sum_s = SUM_W'(acc_r) + SUM_W'(cnt_s);

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_n = state_r;
    word_n  = word_r;
    idx_n   = idx_r;
    acc_n   = acc_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_n = RUN;
          word_n  = PAD_W'(bus.in_data);
          idx_n   = '0;
          acc_n   = '0;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        acc_n  = sum_s[OUT_W-1:0];
        word_n = word_r >> SLICE_W;
        idx_n  = idx_r + IDX_W'(1);
        if (idx_r == LAST_IDX) begin
          state_n = DONE;
        end else begin
          state_n = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      word_r      <= '0;
      idx_r       <= '0;
      acc_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      word_r      <= word_n;
      idx_r       <= idx_n;
      acc_r       <= acc_n;
      in_ready_r  <= (state_n == IDLE);
      out_valid_r <= (state_n == DONE);
      busy_r      <= (state_n != IDLE);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_count = acc_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Scoreboard bench for popcount_seq_ctrl: a 40-bit and a 12-bit (padded) instance,
// expected counts from $countones, checked by independent monitors.
module tb_popcount_seq_ctrl;

  localparam int NS40 = 8;
  localparam int NS12 = 3;

  typedef struct {
    int cnt;
    int acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy40, busy12;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q40[$];
  exp_t q12[$];
  int   sent40 = 0, recv40 = 0, sent12 = 0, recv12 = 0;
  int   hs40 = 0, last_acc40 = 0, last_acc12 = 0;
  bit   ov_prev40 = 1'b0, ov_prev12 = 1'b0;
  bit   rand_ready = 1'b0;

  popcount_seq_ctrl_if #(.WIDTH(40)) bus40 ();
  popcount_seq_ctrl_if #(.WIDTH(12)) bus12 ();

  popcount_seq_ctrl #(.WIDTH(40)) u40 (.clk(clk), .rst_n(rst_n), .bus(bus40.slave), .busy(busy40));
  popcount_seq_ctrl #(.WIDTH(12)) u12 (.clk(clk), .rst_n(rst_n), .bus(bus12.slave), .busy(busy12));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard for the 40-bit instance: latency on out_valid rise, value on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev40 = 1'b0;
    end else begin
      if (bus40.out_valid && !ov_prev40) begin
        if (q40.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected40 actual=out_valid required=no output (cycle %0d)", cyc);
        end else begin
          check("latency40", cyc - q40[0].acc, NS40);
        end
      end
      if (bus40.out_valid && bus40.out_ready && q40.size() != 0) begin
        exp_t e;
        e = q40.pop_front();
        check("count40", bus40.out_count, e.cnt);
        recv40++;
        hs40 = cyc + 1;
      end
      ov_prev40 = bus40.out_valid;
    end
  end

  // Scoreboard for the 12-bit instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev12 = 1'b0;
    end else begin
      if (bus12.out_valid && !ov_prev12) begin
        if (q12.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected12 actual=out_valid required=no output (cycle %0d)", cyc);
        end else begin
          check("latency12", cyc - q12[0].acc, NS12);
        end
      end
      if (bus12.out_valid && bus12.out_ready && q12.size() != 0) begin
        exp_t e;
        e = q12.pop_front();
        check("count12", bus12.out_count, e.cnt);
        recv12++;
      end
      ov_prev12 = bus12.out_valid;
    end
  end

  // Random consumer back-pressure, changed just after the active edge.
  always begin
    @(posedge clk);
    #1;
    if (rand_ready) bus40.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send40(input logic [39:0] d, input bit hold);
    int n;
    exp_t e;
    bus40.in_valid = 1'b1;
    bus40.in_data  = d;
    n = 0;
    while (!bus40.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus40.in_ready) begin
      check("accept_timeout40", n, 0);
      bus40.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.cnt = $countones(d);
    e.acc = cyc;
    q40.push_back(e);
    sent40++;
    last_acc40 = cyc;
    if (!hold) bus40.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send12(input logic [11:0] d);
    int n;
    exp_t e;
    bus12.in_valid = 1'b1;
    bus12.in_data  = d;
    n = 0;
    while (!bus12.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus12.in_ready) begin
      check("accept_timeout12", n, 0);
      bus12.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.cnt = $countones(d);
    e.acc = cyc;
    q12.push_back(e);
    sent12++;
    last_acc12 = cyc;
    bus12.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q40.size() != 0 || q12.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Main stimulus sequence.
  initial begin
    logic [39:0] d40;
    logic [11:0] d12;
    int a1, a2, bcnt, n;
    logic [5:0] held;

    bus40.in_valid = 1'b0; bus40.in_data = '0; bus40.out_ready = 1'b1;
    bus12.in_valid = 1'b0; bus12.in_data = '0; bus12.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready40", bus40.in_ready, 1);
    check("rst_out_valid40", bus40.out_valid, 0);
    check("rst_out_count40", bus40.out_count, 0);
    check("rst_busy40", busy40, 0);
    check("rst_in_ready12", bus12.in_ready, 1);
    check("rst_busy12", busy12, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset on the 4th RUN cycle aborts the word silently.
    bus40.in_valid = 1'b1;
    bus40.in_data  = 40'hFF_FFFF_FFFF;
    @(posedge clk);
    #1;
    bus40.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", bus40.in_ready, 1);
    check("midrst_out_valid", bus40.out_valid, 0);
    check("midrst_out_count", bus40.out_count, 0);
    check("midrst_busy", busy40, 0);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);

    // All ones: count 40, busy for RUN (8) plus one DONE cycle.
    send40(40'hFF_FFFF_FFFF, 1'b0);
    bcnt = 0;
    repeat (20) begin
      if (busy40) bcnt++;
      @(negedge clk);
    end
    check("busy_cycles40", bcnt, NS40 + 1);

    // Zero word then 1 with in_valid held: 10-cycle period.
    send40(40'h0, 1'b1);
    a1 = last_acc40;
    send40(40'h1, 1'b0);
    a2 = last_acc40;
    check("b2b_gap_after_hs", a2 - hs40, 1);
    check("b2b_period", a2 - a1, NS40 + 2);
    drain(50);

    // Output stall: outputs hold and further words are refused.
    bus40.out_ready = 1'b0;
    send40(40'hA5_5A0F_F0C3, 1'b0);
    n = 0;
    while (!bus40.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_reach_done", bus40.out_valid, 1);
    held = bus40.out_count;
    check("stall_value", held, $countones(40'hA5_5A0F_F0C3));
    for (int i = 0; i < 20; i++) begin
      bus40.in_valid = 1'($urandom_range(0, 1));
      bus40.in_data  = 40'({$urandom(), $urandom()});
      @(negedge clk);
      check("stall_out_valid", bus40.out_valid, 1);
      check("stall_out_count", bus40.out_count, held);
      check("stall_in_ready", bus40.in_ready, 0);
    end
    bus40.in_valid = 1'b0;
    @(posedge clk);
    #1;
    bus40.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_release_out_valid", bus40.out_valid, 0);
    check("stall_release_in_ready", bus40.in_ready, 1);

    // Padded slice on the 12-bit instance.
    send12(12'hA5C);
    send12(12'h800);
    send12(12'hFFF);
    for (int i = 0; i < 100; i++) begin
      d12 = 12'($urandom());
      send12(d12);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain(100);

    // Randomised words with random back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 9))
        0: d40 = 40'h0;
        1: d40 = 40'hFF_FFFF_FFFF;
        default: d40 = 40'({$urandom(), $urandom()});
      endcase
      send40(d40, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    bus40.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rand_ready = 1'b0;
    bus40.out_ready = 1'b1;
    @(negedge clk);
    drain(200);
    repeat (5) @(negedge clk);

    check("drain40", q40.size(), 0);
    check("drain12", q12.size(), 0);
    check("words40", recv40, sent40);
    check("words12", recv12, sent12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
